nibble_add_seq: RTL and testbench
=================================

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operation; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 A  input  W  first operand; sampled with start.
REQ-007 B  input  W  second operand; sampled with start.
REQ-008 busy  output  1  high while the state is RUN.
REQ-009 done  output  1  one-cycle pulse; high while the state is DONE.
REQ-010 Y  output  W  result, two's-complement sum or difference.
REQ-011 CarryOUT  output  1  carry out of the MSB slice; for sub, 1 means no borrow.
REQ-012 overflow  output  1  signed overflow of the W-bit operation.

Function
REQ-013 The block SHALL use exactly one instance of the team's 4-bit ripple adder `addition` as its only arithmetic datapath, time-shared across slices.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 Transitions:
  - IDLE->RUN on start=1.
  - RUN->DONE on the edge that processes slice NIBBLES-1.
  - DONE->IDLE unconditionally on the next edge.
REQ-016 On acceptance (edge E0), the block SHALL:
  - register A;
  - register B, or ~B when sub=1;
  - set the carry register to sub;
  - set the slice index to 0.
REQ-017 In RUN, each edge SHALL:
  - present slice[idx] of the operands and the carry register to the adder;
  - store the 4-bit sum into accumulator slice idx;
  - store the adder's carry out into the carry register;
  - increment idx.
REQ-018 Latency: with start accepted at E0, slices are processed at E1..E_NIBBLES and done is high for exactly one cycle, between E_NIBBLES and E_NIBBLES+1.
REQ-019 Y, CarryOUT and overflow SHALL be loaded only on the edge entering DONE. They SHALL hold that value until the next completion or reset, and SHALL never show partial results.
REQ-020 overflow SHALL equal the carry into bit W-1 XOR the carry out of bit W-1. The carry into bit W-1 is derived from the MSB slice's operand bits and sum bit.
REQ-021 start while in RUN or DONE SHALL be ignored, with no queuing. Operand, sub and start changes after E0 SHALL not affect the operation in flight.
REQ-022 A start asserted in the IDLE cycle following DONE SHALL be accepted normally, giving a throughput of one operation per NIBBLES+2 cycles.
REQ-023 busy and done SHALL never be high in the same cycle.

Reset
REQ-024 When rst=1 at an edge, the block SHALL take the following values after that edge:
  - state = IDLE;
  - busy = 0, done = 0;
  - Y = 0, CarryOUT = 0, overflow = 0;
  - idx = 0, carry register = 0, accumulator = 0.
REQ-025 rst SHALL have priority over start. A reset mid-RUN SHALL abort the operation with no done pulse and no output update.
REQ-026 After rst is deasserted, start is accepted on the first edge.

Verification
REQ-027 A=0x1234, B=0x0FFF, sub=0 -> done 5 cycles after E0 is not counted; done high between E4 and E5; Y=0x2233, CarryOUT=0, overflow=0.
REQ-028 A=0x7FFF, B=0x0001, sub=0 -> Y=0x8000, CarryOUT=0, overflow=1. Also A=0xFFFF, B=0x0001 -> Y=0x0000, CarryOUT=1, overflow=0.
REQ-029 A=0x0005, B=0x0007, sub=1 -> Y=0xFFFE, CarryOUT=0, overflow=0. Also A=0x8000, B=0x0001, sub=1 -> Y=0x7FFF, CarryOUT=1, overflow=1.
REQ-030 Start 0x1111+0x2222, then hold start=1 with new operands during RUN/DONE -> single done with Y=0x3333. A second operation begins only in the following IDLE cycle.
REQ-031 Complete one operation (Y=0x3333), start another, assert rst for one edge at E2 -> busy=0 and Y=0x0000 after that edge, and no done pulse within 10 cycles.
REQ-032 Back-to-back: start asserted in the IDLE cycle after each done for 3 operations -> done pulses spaced exactly 6 cycles apart, each with the correct Y.

Source files
------------

// File: rtl/nibble_add_seq.sv
// Sequential W-bit adder/subtractor that time-shares one 4-bit ripple adder
// across NIBBLES slices, least-significant slice first.

module addition (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   Y,
    output logic                   CarryOUT,
    output logic                   overflow
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     y_q, y_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             msb_cin;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[4*i +: 4];
                slice_b = b_q[4*i +: 4];
            end
        end
    end

    addition u_add (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_sum),
        .cout (slice_cout)
    );

    // Carry into the top bit recovered from the MSB slice's operand and sum bits.
    assign msb_cin = slice_a[3] ^ slice_b[3] ^ slice_sum[3];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        y_d     = y_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end

            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        acc_d[4*i +: 4] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    // Outputs update only here, so Y never shows a partial result.
                    idx_d   = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                    y_d     = acc_d;
                    cout_d  = slice_cout;
                    ovf_d   = msb_cin ^ slice_cout;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    busy_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Y        = y_q;
    assign CarryOUT = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.

module tb_nibble_add_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] Y;
    logic         CarryOUT;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done_cyc = 0;

    logic [W-1:0] last_y = '0;

    nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .A        (a_in),
        .B        (b_in),
        .busy     (busy),
        .done     (done),
        .Y        (Y),
        .CarryOUT (CarryOUT),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result {overflow, carry/no-borrow, Y} from integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        logic [W:0]   full;
        logic [W-1:0] y;
        logic         c;
        logic         v;
        full = '0;
        if (s) begin
            y = a - b;
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            y = full[W-1:0];
            c = full[W];
            v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
        end
        return {v, c, y};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Present an operation, let edge E0 accept it, then scramble the inputs.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic keep_start);
        a_in  = a;
        b_in  = b;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = keep_start;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        sub   = 1'($urandom_range(0, 1));
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int start_cyc;
        bit seen;
        start_cyc = cyc;
        seen = 1'b0;
        for (int k = 0; k < 3 * NIBBLES + 4 && !seen; k++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_busy_done_excl"}, 32'(busy & done), 32'd0);
            if (done) begin
                seen = 1'b1;
            end else begin
                checkOutput({tag, "_busy_in_run"}, 32'(busy), 32'd1);
                checkOutput({tag, "_y_no_partial"}, 32'(Y), 32'(last_y));
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cyc - start_cyc), 32'(NIBBLES));
        last_done_cyc = cyc;
    endtask

    // Check the result while done is high, then step into the following IDLE cycle.
    task automatic finish_op(input string tag, input logic [W+1:0] exp);
        checkOutput({tag, "_y"}, 32'(Y), 32'(exp[W-1:0]));
        checkOutput({tag, "_cout"}, 32'(CarryOUT), 32'(exp[W]));
        checkOutput({tag, "_ovf"}, 32'(overflow), 32'(exp[W+1]));
        last_y = exp[W-1:0];
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_y_hold"}, 32'(Y), 32'(exp[W-1:0]));
    endtask

    task automatic run_and_check(input string tag, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic s);
        logic [W+1:0] exp;
        exp = model(a, b, s);
        applyStimulus(a, b, s, 1'b0);
        wait_done(tag);
        finish_op(tag, exp);
    endtask

    initial begin
        logic [W+1:0] exp2;
        int d0;
        int d1;

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_y", 32'(Y), 32'd0);
        checkOutput("reset_cout", 32'(CarryOUT), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Start is accepted on the first edge after reset is released.
        run_and_check("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0);
        checkOutput("add_1234_0fff_const", 32'(last_y), 32'h2233);
        run_and_check("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0);
        run_and_check("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0);
        run_and_check("sub_0005_0007", 16'h0005, 16'h0007, 1'b1);
        run_and_check("sub_8000_0001", 16'h8000, 16'h0001, 1'b1);
        run_and_check("sub_equal", 16'hA5A5, 16'hA5A5, 1'b1);

        // start held high through RUN/DONE with changing operands.
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b1);
        wait_done("hold");
        finish_op("hold", model(16'h1111, 16'h2222, 1'b0));
        checkOutput("hold_const", 32'(last_y), 32'h3333);
        exp2 = model(a_in, b_in, sub);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("hold_second_accept", 32'(busy), 32'd1);
        wait_done("hold2");
        finish_op("hold2", exp2);

        // Reset during RUN aborts the operation.
        run_and_check("pre_reset", 16'h1111, 16'h2222, 1'b0);
        applyStimulus(16'h4321, 16'h1234, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_y", 32'(Y), 32'd0);
        checkOutput("abort_cout", 32'(CarryOUT), 32'd0);
        checkOutput("abort_ovf", 32'(overflow), 32'd0);
        last_y = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_done", 32'(done), 32'd0);
            checkOutput("abort_y_stays", 32'(Y), 32'd0);
        end

        // A one-edge reset immediately followed by a request.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_and_check("after_reset", 16'h0F0F, 16'hF0F1, 1'b0);

        // Back-to-back operations, each started in the IDLE cycle after done.
        run_and_check("b2b_0", 16'h1357, 16'h2468, 1'b0);
        d0 = last_done_cyc;
        run_and_check("b2b_1", 16'h9000, 16'h7000, 1'b1);
        d1 = last_done_cyc;
        checkOutput("b2b_spacing_01", 32'(d1 - d0), 32'(NIBBLES + 2));
        run_and_check("b2b_2", 16'hFFFE, 16'h0003, 1'b0);
        checkOutput("b2b_spacing_12", 32'(last_done_cyc - d1), 32'(NIBBLES + 2));

        for (int n = 0; n < 30; n++) begin
            run_and_check("rand", pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
